// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Consumes a three-digit packed BCD word ({hundreds, tens, ones}) and scans
// it digit by digit. Four slots make up one frame: ones, tens, hundreds and an
// idle slot, so each lit digit gets a 1/4 duty cycle.
//
// Features:
//   - Frame-synchronous shadow capture of the BCD word and the blanking
//     enable. The display never shows a mix of old and new digits.
//   - Optional leading-zero blanking of the hundreds and tens digits.
//   - Nibbles above 9 are drawn as a dash. They are never blanked.
//   - A dead time at the start of every slot, with all anodes off, to
//     suppress ghosting while the segment lines settle.
// Segments, anodes and the decimal point are all active-low.
// Every output is registered, so the outputs lag the scan state by one cycle.

module bcd_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    // Prescaler width: wide enough to hold REFRESH_DIV-1.
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);

    // Scan slot encoding. Slot 3 is the idle slot: every anode is off in it.
    localparam logic [1:0] SLOT_ONES = 2'd0;
    localparam logic [1:0] SLOT_TENS = 2'd1;
    localparam logic [1:0] SLOT_HUND = 2'd2;
    localparam logic [1:0] SLOT_IDLE = 2'd3;

    // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Scan position.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    // Shadow copies of the inputs. They are loaded only at the frame boundary.
    logic [11:0]      bcd_q, bcd_d;
    logic             lz_q,  lz_d;

    // Registered outputs.
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q,  an_d;
    logic             tick_q, tick_d;

    // Decode and blanking helpers.
    logic             slot_end;
    logic             frame_end;
    logic [3:0]       ones_nib, tens_nib, hund_nib;
    logic             blank_hund, blank_tens;
    logic [3:0]       cur_nib;
    logic             cur_blank;
    logic             slot_active;

    // Convert one BCD nibble to its active-low segment pattern.
    // Any nibble that is not a valid decimal digit shows a dash.
    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        logic [6:0] pattern;
        case (nib)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // Advance the prescaler and step to the next slot when the prescaler wraps.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == SLOT_IDLE);
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Capture the inputs into the shadow registers only at the frame boundary.
    // Input changes in the middle of a frame wait for the next frame.
    always_comb begin
        bcd_d = bcd_q;
        lz_d  = lz_q;
        if (frame_end) begin
            bcd_d = bcd;
            lz_d  = blank_lz;
        end
    end

    // Leading-zero blanking on the shadow value.
    // A non-decimal nibble counts as nonzero, so it is never blanked.
    always_comb begin
        ones_nib   = bcd_q[3:0];
        tens_nib   = bcd_q[7:4];
        hund_nib   = bcd_q[11:8];
        blank_hund = lz_q && (hund_nib == 4'd0);
        blank_tens = lz_q && (hund_nib == 4'd0) && (tens_nib == 4'd0);
    end

    // Select the digit for the current slot, and whether that digit is blanked.
    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b1;
        case (idx_q)
            SLOT_ONES: begin
                cur_nib   = ones_nib;
                cur_blank = 1'b0;
            end
            SLOT_TENS: begin
                cur_nib   = tens_nib;
                cur_blank = blank_tens;
            end
            SLOT_HUND: begin
                cur_nib   = hund_nib;
                cur_blank = blank_hund;
            end
            default: begin
                cur_nib   = 4'd0;
                cur_blank = 1'b1;
            end
        endcase
    end

    // Drive an anode only after the dead time, only outside the idle slot, and
    // only for a digit that is not blanked. At all other times the display is dark.
    always_comb begin
        slot_active = (cnt_q >= CNT_GHOST) && (idx_q != SLOT_IDLE) && !cur_blank;
        if (slot_active) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode_digit(cur_nib);
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
        tick_d = frame_end;
    end

    // Update the scan state, the shadow registers and the output registers.
    // Reset takes priority over a frame-boundary load in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= SLOT_ONES;
            bcd_q  <= 12'h000;
            lz_q   <= 1'b0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            bcd_q  <= bcd_d;
            lz_q   <= lz_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            tick_q <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = 1'b1;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan
// Scoreboard bench for bcd_seg_scan with REFRESH_DIV=8 and GHOST_CYC=2.
// For each frame, the stimulus side pushes the {bcd, blank_lz} value that the
// frame must display. The monitor pops one entry at every frame start (reset
// release or frame_tick). It builds the whole 32-cycle output waveform from the
// display rules and compares it cycle by cycle.

module tb_bcd_seg_scan;

    localparam int DIV   = 8;
    localparam int GHOST = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    bcd_seg_scan #(
        .REFRESH_DIV(DIV),
        .GHOST_CYC  (GHOST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd       (bcd),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] val;
        logic        lz;
    } frame_exp_t;

    frame_exp_t exp_q[$];

    int checks         = 0;
    int errors         = 0;
    int frames_pushed  = 0;
    int frames_started = 0;
    int frame_no       = 0;
    bit stopping       = 1'b0;
    bit rst_at_edge    = 1'b0;

    // Display rules: segment patterns for the decimal digits, active-low.
    logic [6:0] digit_seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    // Expected waveform of the current frame: {an, seg, dp, frame_tick}.
    logic [12:0] exp_frame [FRAME];
    bit          capturing = 1'b0;
    int          cyc       = 0;
    int          reg_mis   = 0;
    int          first_off = 0;
    logic [12:0] first_act;
    logic [12:0] first_exp;

    // Random BCD word. It favours zero nibbles to exercise blanking, and
    // sometimes includes non-decimal nibbles.
    function automatic logic [11:0] randBcd();
        logic [11:0] v;
        for (int n = 0; n < 3; n++) begin
            logic [3:0] nib;
            nib = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) nib = 4'd0;
            v[n*4 +: 4] = nib;
        end
        return v;
    endfunction

    // Pattern shown for one nibble: the digit pattern, or a dash above 9.
    function automatic logic [6:0] segFor(input logic [3:0] nib);
        if (nib > 4'd9) return 7'b0111111;
        return digit_seg[nib];
    endfunction

    // Build the waveform the display must show over one frame. Offset 0 is the
    // cycle where slot 0 / count 0 becomes the scan state. The outputs lag the
    // scan state by one cycle.
    function automatic void buildFrame(input frame_exp_t e, input bit from_tick);
        logic [3:0] dig [3];
        bit         blank [3];
        dig[0]   = e.val[3:0];
        dig[1]   = e.val[7:4];
        dig[2]   = e.val[11:8];
        blank[0] = 1'b0;
        blank[1] = e.lz && (dig[2] == 4'd0) && (dig[1] == 4'd0);
        blank[2] = e.lz && (dig[2] == 4'd0);
        for (int i = 0; i < FRAME; i++) begin
            logic [3:0] a;
            logic [6:0] s;
            int         st;
            int         slot;
            int         pos;
            a  = 4'b1111;
            s  = 7'b1111111;
            st = i - 1;
            if (st >= 0) begin
                slot = st / DIV;
                pos  = st % DIV;
                if (slot < 3 && pos >= GHOST && !blank[slot]) begin
                    a = 4'b1111;
                    a[slot] = 1'b0;
                    s = segFor(dig[slot]);
                end
            end
            exp_frame[i] = {a, s, 1'b1, (i == 0) ? from_tick : 1'b0};
        end
    endfunction

    // Compare one cycle of the frame against the expected waveform.
    // Give one verdict for each group of eight cycles.
    task automatic checkOutput();
        logic [12:0] act;
        act = {an, seg, dp, frame_tick};
        if (act !== exp_frame[cyc]) begin
            if (reg_mis == 0) begin
                first_off = cyc;
                first_act = act;
                first_exp = exp_frame[cyc];
            end
            reg_mis++;
        end
        if (cyc % DIV == DIV - 1) begin
            checks++;
            if (reg_mis != 0) begin
                errors++;
                $display("[TB] FAIL frame%0d_part%0d: %0d bad cycle(s), offset %0d got {an,seg,dp,tick}=%b required %b",
                         frame_no, cyc / DIV, reg_mis, first_off, first_act, first_exp);
            end
            reg_mis = 0;
        end
        cyc++;
        if (cyc == FRAME) capturing = 1'b0;
    endtask

    task automatic startFrame(input bit from_tick);
        frame_exp_t e;
        e = exp_q.pop_front();
        frames_started++;
        frame_no++;
        buildFrame(e, from_tick);
        cyc       = 0;
        reg_mis   = 0;
        capturing = 1'b1;
        checkOutput();
    endtask

    task automatic checkReset();
        logic [12:0] act;
        act = {an, seg, dp, frame_tick};
        checks++;
        if (act !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got {an,seg,dp,tick}=%b required 1111111111110", act);
        end
    endtask

    // Remember whether reset was sampled at the most recent rising edge.
    initial forever begin
        @(posedge clk);
        rst_at_edge = rst;
    end

    // Monitor: check reset values, start a frame at each frame start, and
    // compare the outputs cycle by cycle.
    initial forever begin
        @(negedge clk);
        if (rst_at_edge) begin
            checkReset();
            capturing = 1'b0;
            if (!rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_empty: got 0 entries required 1 at reset release");
                end else begin
                    startFrame(1'b0);
                end
            end
        end else if (capturing) begin
            checkOutput();
        end else if (frame_tick === 1'b1) begin
            if (exp_q.size() != 0) begin
                startFrame(1'b1);
            end else if (!stopping) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries required 1 at frame_tick");
            end
        end
    end

    task automatic finishSim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Wait, with a cycle limit, for the next frame_tick as seen at a falling edge.
    task automatic waitTick();
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL tick_timeout: got no frame_tick in %0d cycles required one every %0d", 3 * FRAME, FRAME);
        finishSim();
    endtask

    task automatic pushExp(input logic [11:0] v, input logic lz);
        exp_q.push_back('{val: v, lz: lz});
        frames_pushed++;
    endtask

    // At a frame start, first drive junk in the middle of the frame, then drive
    // the value the next frame must show.
    task automatic applyStimulus(input logic [11:0] v, input logic lz);
        waitTick();
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        bcd      = randBcd();
        blank_lz = 1'($urandom_range(0, 1));
        repeat ($urandom_range(3, 10)) @(posedge clk);
        #1;
        bcd      = v;
        blank_lz = lz;
        pushExp(v, lz);
    endtask

    // One-cycle reset in slot 2 at count 5 (frame offset 21).
    task automatic midFrameReset(input logic [11:0] next_v, input logic next_lz);
        waitTick();
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        pushExp(12'h000, 1'b0);
        bcd      = next_v;
        blank_lz = next_lz;
        pushExp(next_v, next_lz);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [11:0] dir_val [8] = '{12'h427, 12'h005, 12'h050, 12'h000,
                                 12'h0A3, 12'h123, 12'h456, 12'h987};
    logic        dir_lz  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Stimulus: power-on reset, directed frames, a mid-frame reset, then random frames.
    initial begin
        rst      = 1'b1;
        bcd      = 12'h000;
        blank_lz = 1'b0;
        pushExp(12'h000, 1'b0);
        bcd      = dir_val[0];
        blank_lz = dir_lz[0];
        pushExp(dir_val[0], dir_lz[0]);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 1; k < 8; k++) applyStimulus(dir_val[k], dir_lz[k]);

        midFrameReset(12'h306, 1'b1);

        for (int k = 0; k < 14; k++) applyStimulus(randBcd(), 1'($urandom_range(0, 1)));
        stopping = 1'b1;

        waitTick();
        repeat (FRAME + 2) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        checks++;
        if (frames_started != frames_pushed) begin
            errors++;
            $display("[TB] FAIL frame_count: got %0d frames displayed required %0d", frames_started, frames_pushed);
        end
        finishSim();
    end

endmodule
